// File: rtl/wb_select_seq.sv
// Registered write-back select stage: picks one of N_SRC sources per cycle and
// splits the double-width product into lo/hi register writes over two cycles.
module wb_select_seq #(
    parameter int DATA_W  = 32,
    parameter int N_SRC   = 4,
    parameter int DEST_W  = 5,
    parameter int ZERO_RO = 1,
    localparam int SEL_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SEL_W-1:0]              md_sel,
    input  logic [DEST_W-1:0]             dest_addr,
    input  logic [(N_SRC-1)*DATA_W-1:0]   src_data,
    input  logic [2*DATA_W-1:0]           product,
    output logic                          wr_en,
    output logic [DEST_W-1:0]             wr_addr,
    output logic [DATA_W-1:0]             wr_data,
    output logic                          sel_err
);

    typedef enum logic {IDLE, HI} state_t;

    state_t              state_q, state_d;
    logic                wr_en_q, wr_en_d;
    logic [DEST_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                sel_err_q, sel_err_d;
    logic [DATA_W-1:0]   hi_data_q, hi_data_d;
    logic [DEST_W-1:0]   hi_addr_q, hi_addr_d;

    logic                accept;
    logic [31:0]         sel_ext;
    logic [DATA_W-1:0]   src_word;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;
    assign sel_ext  = {{(32-SEL_W){1'b0}}, md_sel};

    // Explicit mux keeps out-of-range selects from indexing past src_data.
    always_comb begin
        src_word = '0;
        for (int k = 0; k < N_SRC-1; k++) begin
            if (sel_ext == 32'(k)) src_word = src_data[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        sel_err_d = 1'b0;
        hi_data_d = hi_data_q;
        hi_addr_d = hi_addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_ext < 32'(N_SRC-1)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = dest_addr;
                        wr_data_d = src_word;
                    end else if (sel_ext == 32'(N_SRC-1)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = dest_addr;
                        wr_data_d = product[DATA_W-1:0];
                        hi_data_d = product[2*DATA_W-1:DATA_W];
                        hi_addr_d = dest_addr + DEST_W'(1);
                        state_d   = HI;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            HI: begin
                wr_en_d   = 1'b1;
                wr_addr_d = hi_addr_q;
                wr_data_d = hi_data_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // r0 is hardwired: suppress the strobe but keep the sequence intact.
        if (ZERO_RO != 0 && wr_addr_d == '0) wr_en_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            sel_err_q <= 1'b0;
            hi_data_q <= '0;
            hi_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            sel_err_q <= sel_err_d;
            hi_data_q <= hi_data_d;
            hi_addr_q <= hi_addr_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign sel_err = sel_err_q;

endmodule
